// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port RAM with a defined collision policy,
// selectable read-during-write mode and a sequential clear engine after reset.
module dual_port_ram_param #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 4,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              dvalid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              dvalid_b,
    output logic              busy,
    output logic              collision,
    output logic [7:0]        coll_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic                dvalid_a_q, dvalid_a_d, dvalid_b_q, dvalid_b_d;
    logic                collision_q, collision_d;
    logic [7:0]          coll_cnt_q, coll_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_clear, acc_a, acc_b, wr_a, wr_b, coll;
    logic                p0_we, p1_we;
    logic [ADDR_W-1:0]   p0_addr;
    logic [DATA_W-1:0]   p0_data;

    always_comb begin
        in_clear = (state_q == ST_CLEAR);
        acc_a    = en_a & ~in_clear;
        acc_b    = en_b & ~in_clear;
        wr_a     = acc_a & we_a;
        wr_b     = acc_b & we_b;
        coll     = acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);

        // Write port 0 is shared by the clear engine and port A; port B loses a write-write collision.
        p0_we    = ~rst & (in_clear | wr_a);
        p0_addr  = in_clear ? clr_ptr_q : addr_a;
        p0_data  = in_clear ? '0 : din_a;
        p1_we    = ~rst & wr_b & ~(coll & we_a);

        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (in_clear) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        end
        busy_d = (state_d == ST_CLEAR);

        dout_a_d   = dout_a_q;
        dvalid_a_d = acc_a;
        if (acc_a) dout_a_d = (we_a && WRITE_FIRST != 0) ? din_a : mem_q[addr_a];
        dout_b_d   = dout_b_q;
        dvalid_b_d = acc_b;
        if (acc_b) dout_b_d = (we_b && WRITE_FIRST != 0) ? din_b : mem_q[addr_b];

        collision_d = coll;
        coll_cnt_d  = (coll && coll_cnt_q != 8'hFF) ? coll_cnt_q + 8'd1 : coll_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            busy_q      <= (CLEAR_ON_RESET != 0);
            clr_ptr_q   <= '0;
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            dvalid_a_q  <= 1'b0;
            dvalid_b_q  <= 1'b0;
            collision_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            clr_ptr_q   <= clr_ptr_d;
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            dvalid_a_q  <= dvalid_a_d;
            dvalid_b_q  <= dvalid_b_d;
            collision_q <= collision_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    // Storage has no reset; the clear engine is the only way it is zeroed.
    always_ff @(posedge clk) begin
        if (p0_we) mem_q[p0_addr] <= p0_data;
        if (p1_we) mem_q[addr_b]  <= din_b;
    end

    assign dout_a    = dout_a_q;
    assign dout_b    = dout_b_q;
    assign dvalid_a  = dvalid_a_q;
    assign dvalid_b  = dvalid_b_q;
    assign busy      = busy_q;
    assign collision = collision_q;
    assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param: a WRITE_FIRST=1 and a WRITE_FIRST=0
// instance share the same stimulus; expected values are hand-computed.
module tb_dual_port_ram_param;

  logic       clk = 1'b0;
  logic       rst, en_a, we_a, en_b, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;
  logic [7:0] dout_a, dout_b, coll_cnt, dout_a0, dout_b0, coll_cnt0;
  logic       dvalid_a, dvalid_b, busy, collision;
  logic       dvalid_a0, dvalid_b0, busy0, collision0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         n;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(4), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a), .dvalid_a(dvalid_a),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b), .dvalid_b(dvalid_b),
    .busy(busy), .collision(collision), .coll_cnt(coll_cnt)
  );

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(4), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .dvalid_a(dvalid_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .dvalid_b(dvalid_b0),
    .busy(busy0), .collision(collision0), .coll_cnt(coll_cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    step();
    chk("rst_busy", busy, 1);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_dvalid_a", dvalid_a, 0);
    chk("rst_collision", collision, 0);
    chk("rst_coll_cnt", coll_cnt, 0);
    rst = 1'b0;

    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("clear_len", n, 16);
    chk("clear_len_wf0", busy0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 4'(i), 8'h00, 1, 0, 4'(15 - i), 8'h00);
      step();
      chk("clear_rd_a", dout_a, 0);
      chk("clear_rd_b", dout_b, 0);
      chk("clear_dvalid_a", dvalid_a, 1);
    end

    drive(1, 1, 4'd3, 8'h5A, 1, 1, 4'd7, 8'hC3);
    step();
    chk("indep_no_coll", collision, 0);
    drive(1, 0, 4'd7, 8'h00, 1, 0, 4'd3, 8'h00);
    step();
    chk("indep_rd_a", dout_a, 8'hC3);
    chk("indep_rd_b", dout_b, 8'h5A);
    chk("indep_dvalid_b", dvalid_b, 1);

    drive(1, 1, 4'd5, 8'h11, 1, 1, 4'd5, 8'h22);
    step();
    chk("ww_coll_pulse", collision, 1);
    chk("ww_coll_cnt", coll_cnt, 1);
    drive(1, 0, 4'd5, 8'h00, 1, 0, 4'd5, 8'h00);
    step();
    chk("rr_no_coll", collision, 0);
    chk("ww_rd_a", dout_a, 8'h11);
    chk("ww_rd_b", dout_b, 8'h11);
    chk("rr_coll_cnt", coll_cnt, 1);

    drive(1, 1, 4'd9, 8'hAA, 0, 0, 4'd0, 8'h00);
    step();
    drive(1, 1, 4'd9, 8'hBB, 1, 0, 4'd9, 8'h00);
    step();
    chk("wr_coll_rd_b", dout_b, 8'hAA);
    chk("wr_coll_rd_b_wf0", dout_b0, 8'hAA);
    chk("wr_first_a", dout_a, 8'hBB);
    chk("rd_first_a_wf0", dout_a0, 8'hAA);
    chk("wr_coll_pulse", collision, 1);
    chk("wr_coll_cnt", coll_cnt, 2);
    drive(1, 1, 4'd2, 8'h77, 0, 0, 4'd0, 8'h00);
    step();
    chk("wr_first_a2", dout_a, 8'h77);
    chk("rd_first_a2_wf0", dout_a0, 8'h00);
    drive(1, 0, 4'd3, 8'h00, 1, 0, 4'd9, 8'h00);
    step();
    chk("rd_a3", dout_a, 8'h5A);
    chk("rd_b9", dout_b, 8'hBB);

    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    step();
    chk("idle_dvalid_a", dvalid_a, 0);
    chk("idle_dvalid_b", dvalid_b, 0);
    chk("idle_hold_a", dout_a, 8'h5A);
    chk("idle_hold_b", dout_b, 8'hBB);

    drive(1, 1, 4'd1, 8'h01, 1, 1, 4'd1, 8'h02);
    for (int i = 0; i < 252; i++) step();
    chk("sat_cnt_254", coll_cnt, 254);
    for (int i = 0; i < 48; i++) step();
    chk("sat_cnt_255", coll_cnt, 255);
    chk("sat_cnt_255_wf0", coll_cnt0, 255);

    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_clear_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("restart_busy", busy, 1);
    chk("restart_coll_cnt", coll_cnt, 0);
    rst = 1'b0;
    drive(1, 1, 4'd4, 8'hFF, 1, 1, 4'd4, 8'hEE);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
      chk("busy_dvalid_a", dvalid_a, 0);
      chk("busy_no_coll", collision, 0);
    end
    chk("restart_len", n, 16);
    chk("busy_coll_cnt", coll_cnt, 0);
    drive(1, 0, 4'd4, 8'h00, 1, 0, 4'd1, 8'h00);
    step();
    chk("lost_wr_a4", dout_a, 8'h00);
    chk("cleared_b1", dout_b, 8'h00);
    chk("post_clear_dvalid", dvalid_a, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
